hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Produces the stall, flush and forwarding controls consumed by the F/D, D/E, E/M and M/W pipeline registers and the E-stage operand muxes.
- StallD drives the F/D register enable pin: 1 = hold. FlushD drives the F/D clear pin.
- Adds a sequential memory-wait FSM with timeout so multi-cycle data memory can stall the pipe.

Parameters:
REG_W, 5, register index width
TIMEOUT, 16, maximum consecutive memory-stall cycles before forced release (>=2)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
Rs1D, Rs2D  in  REG_W  source registers in Decode
Rs1E, Rs2E, RdE  in  REG_W  source and destination registers in Execute
RdM, RdW  in  REG_W  destination registers in Memory and Writeback
RegWriteM, RegWriteW  in  1  writeback enables in M and W
LoadE  in  1  instruction in E is a load (ResultSrcE[0])
PCSrcE  in  1  taken branch or jump resolved in E
MemReqM  in  1  load/store active in M
MemReadyM  in  1  data memory acknowledge
ForwardAE, ForwardBE  out  2  00 = register file, 01 = ResultW, 10 = ALUResultM
StallF, StallD, StallE, StallM  out  1  hold the stage register
FlushD, FlushE, FlushW  out  1  clear the stage register (insert bubble)
MemErr  out  1  sticky memory-timeout flag
LwStallCnt, MemStallCnt, FlushCnt  out  CNT_W  performance counters

Behaviour:
- Forwarding (combinational), ForwardAE:
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - M has priority over W. ForwardBE uses the same rules with Rs2E.
- lwStall = LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- memStall: from the FSM, below.
- Output equations:
  - StallF = StallD = lwStall | memStall
  - StallE = StallM = memStall
  - FlushW = memStall
  - FlushD = PCSrcE & ~memStall
  - FlushE = (lwStall | PCSrcE) & ~memStall
- A branch resolved during a memory stall is held in E by StallE. Its flush is issued in the first cycle after the stall releases.
- FSM states: IDLE, WAIT. Stall counter wcnt has width $clog2(TIMEOUT+1).
  - IDLE:
    - MemReqM && !MemReadyM: memStall=1, next state WAIT, wcnt<=1.
    - Otherwise memStall=0, wcnt<=0.
  - WAIT:
    - MemReadyM=1: memStall=0, next IDLE, wcnt<=0.
    - !MemReadyM && wcnt<TIMEOUT: memStall=1, wcnt<=wcnt+1, stay.
    - !MemReadyM && wcnt==TIMEOUT: memStall=0 (forced release), MemErr<=1, next IDLE.
  - Maximum stall is TIMEOUT cycles.
- MemErr stays set until reset.
- A back-to-back memory access in IDLE the cycle after release re-enters WAIT normally.
- Reset, at any time including mid-WAIT:
  - state IDLE, wcnt 0, MemErr 0, all counters 0;
  - while reset is high, all Stall*/Flush* = 0 and Forward* = 00.
- Simultaneous lwStall and PCSrcE without memStall: StallF/StallD=1, FlushD=1, FlushE=1. Flush wins in D.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, counters increment by 1 per cycle (saturating at all-ones):
  - LwStallCnt when lwStall && !memStall;
  - MemStallCnt when memStall;
  - FlushCnt when FlushD.
- When undefined, no counter flops are built and the three outputs are tied to 0.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum (FWD_RF=00, FWD_WB=01, FWD_MEM=10);
  - mem_state_t enum (IDLE, WAIT);
  - default TIMEOUT constant.
- One natural sub-module: hazard_fwd_sel, the combinational forwarding selector, instantiated twice (A and B).

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Repeat with RdM=0 -> ForwardAE=01. Rs2E=7 -> ForwardBE=00.
- LoadE=1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for exactly 1 cycle. With RdE=0 -> no stall.
- PCSrcE=1, no memory access -> FlushD=FlushE=1, StallF=0.
- MemReqM=1, MemReadyM low 4 cycles then high -> StallF/D/E/M and FlushW high exactly 4 cycles, MemErr=0. Perf: MemStallCnt=4.
- MemReadyM held low, TIMEOUT=16 -> stall exactly 16 cycles, release in cycle 17, MemErr=1 sticky. Assert reset mid-WAIT -> MemErr=0, state IDLE, stalls 0 the next cycle.
- PCSrcE=1 asserted during a memory stall -> FlushD=0 while stalled, FlushD=FlushE=1 in the first cycle after MemReadyM.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the RV32I pipeline hazard controller.
// Perf counters in hazard_ctrl are built only when HAZARD_PERF_EN is defined.
package hazard_pkg;

  localparam int unsigned DEF_REG_W   = 5;
  localparam int unsigned DEF_TIMEOUT = 16;
  localparam int unsigned DEF_CNT_W   = 32;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Combinational E-stage operand forwarding selector; the M stage wins over W.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = DEF_REG_W
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  output fwd_sel_t         sel
);

  // x0 is never a forwarding source.
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush, memory-wait FSM.
// Optional perf counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W   = DEF_REG_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] LwStallCnt,
  output logic [CNT_W-1:0] MemStallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

  mem_state_t        state;
  logic [WCNT_W-1:0] wcnt;
  logic              mem_err_q;
  logic              mem_stall;
  logic              lw_stall;
  logic              flush_d;
  fwd_sel_t          fwd_a;
  fwd_sel_t          fwd_b;

  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (fwd_a)
  );

  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (fwd_b)
  );

  assign lw_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Stall is asserted in the same cycle the memory fails to acknowledge.
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      IDLE:    mem_stall = MemReqM && !MemReadyM;
      WAIT:    mem_stall = !MemReadyM && (wcnt < WCNT_W'(TIMEOUT));
      default: mem_stall = 1'b0;
    endcase
  end

  // Memory-wait FSM; wcnt counts stall cycles already issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MemReqM && !MemReadyM) begin
            state <= WAIT;
            wcnt  <= WCNT_W'(1);
          end else begin
            wcnt <= '0;
          end
        end
        WAIT: begin
          if (MemReadyM) begin
            state <= IDLE;
            wcnt  <= '0;
          end else if (wcnt < WCNT_W'(TIMEOUT)) begin
            wcnt <= wcnt + WCNT_W'(1);
          end else begin
            state     <= IDLE;
            wcnt      <= '0;
            mem_err_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          wcnt  <= '0;
        end
      endcase
    end
  end

  // A branch held in E by a memory stall flushes once the stall drops.
  assign flush_d = PCSrcE & ~mem_stall;

  assign ForwardAE = reset ? FWD_RF : fwd_a;
  assign ForwardBE = reset ? FWD_RF : fwd_b;
  assign StallF    = ~reset & (lw_stall | mem_stall);
  assign StallD    = ~reset & (lw_stall | mem_stall);
  assign StallE    = ~reset & mem_stall;
  assign StallM    = ~reset & mem_stall;
  assign FlushW    = ~reset & mem_stall;
  assign FlushD    = ~reset & flush_d;
  assign FlushE    = ~reset & (lw_stall | PCSrcE) & ~mem_stall;
  assign MemErr    = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] lw_cnt;
  logic [CNT_W-1:0] mem_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lw_cnt    <= '0;
      mem_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      if (lw_stall && !mem_stall && (lw_cnt != '1)) lw_cnt <= lw_cnt + CNT_W'(1);
      if (mem_stall && (mem_cnt != '1)) mem_cnt <= mem_cnt + CNT_W'(1);
      if (flush_d && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign LwStallCnt  = lw_cnt;
  assign MemStallCnt = mem_cnt;
  assign FlushCnt    = flush_cnt;
`else
  assign LwStallCnt  = '0;
  assign MemStallCnt = '0;
  assign FlushCnt    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table for the combinational paths,
// hand-written sequences for the memory-wait FSM, timeout, reset and branch hold.
module tb_hazard_ctrl;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LW   = 7'b1100010;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_BOTH = 7'b1100110;
  localparam logic [6:0] C_MEM  = 7'b1111001;

  logic clk = 1'b0;
  logic reset;
  logic [REG_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [CNT_W-1:0] LwStallCnt, MemStallCnt, FlushCnt;
  logic [6:0] ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr),
    .LwStallCnt(LwStallCnt), .MemStallCnt(MemStallCnt), .FlushCnt(FlushCnt)
  );

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, loade, pcsrc;
    logic [1:0] fa, fb;
    logic [6:0] ctl;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                              input logic rwm, rww, loade, pcsrc,
                              input logic [1:0] fa, fb, input logic [6:0] c);
    vec_t v;
    v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw;
    v.rwm = rwm; v.rww = rww; v.loade = loade; v.pcsrc = pcsrc;
    v.fa = fa; v.fb = fb; v.ctl = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  int stall_cycles;

  initial begin
    vt[0]  = mk(0, 0, 5, 7, 0, 5, 5, 1, 1, 0, 0, 2'b10, 2'b00, C_NONE);
    vt[1]  = mk(0, 0, 5, 7, 0, 0, 5, 1, 1, 0, 0, 2'b01, 2'b00, C_NONE);
    vt[2]  = mk(0, 0, 5, 7, 0, 5, 5, 0, 1, 0, 0, 2'b01, 2'b00, C_NONE);
    vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, C_NONE);
    vt[4]  = mk(0, 0, 1, 9, 0, 9, 9, 1, 1, 0, 0, 2'b00, 2'b10, C_NONE);
    vt[5]  = mk(0, 0, 1, 7, 0, 3, 7, 1, 1, 0, 0, 2'b00, 2'b01, C_NONE);
    vt[6]  = mk(1, 3, 0, 0, 3, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, C_LW);
    vt[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, C_NONE);
    vt[8]  = mk(3, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, C_NONE);
    vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, C_BR);
    vt[10] = mk(4, 0, 0, 0, 4, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, C_BOTH);
    vt[11] = mk(4, 2, 0, 0, 4, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, C_LW);
    vt[12] = mk(6, 6, 0, 0, 5, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, C_NONE);

    // Reset: hazardous inputs must be masked.
    clear_inputs();
    reset = 1;
    RdM = 5; RegWriteM = 1; Rs1E = 5; PCSrcE = 1; MemReqM = 1;
    #2;
    chk("reset_ctl", 32'(ctl), 32'(C_NONE));
    chk("reset_fwd_a", 32'(ForwardAE), 32'd0);
    chk("reset_memerr", 32'(MemErr), 32'd0);
    chk("reset_memstallcnt", MemStallCnt, 32'd0);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    reset = 0;

    // Combinational vectors, one clock each, FSM idle.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      Rs1D = vt[i].rs1d; Rs2D = vt[i].rs2d; Rs1E = vt[i].rs1e; Rs2E = vt[i].rs2e;
      RdE = vt[i].rde; RdM = vt[i].rdm; RdW = vt[i].rdw;
      RegWriteM = vt[i].rwm; RegWriteW = vt[i].rww; LoadE = vt[i].loade; PCSrcE = vt[i].pcsrc;
      #1;
      chk($sformatf("vec%0d_fwd_a", i), 32'(ForwardAE), 32'(vt[i].fa));
      chk($sformatf("vec%0d_fwd_b", i), 32'(ForwardBE), 32'(vt[i].fb));
      chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vt[i].ctl));
    end
    @(negedge clk);
    clear_inputs();
    #1;
`ifdef HAZARD_PERF_EN
    chk("lw_stall_cnt", LwStallCnt, 32'd3);
    chk("flush_cnt", FlushCnt, 32'd2);
`else
    chk("lw_stall_cnt", LwStallCnt, 32'd0);
    chk("flush_cnt", FlushCnt, 32'd0);
`endif

    // Timeout: memory never acknowledges.
    @(negedge clk);
    MemReqM = 1; MemReadyM = 0;
    stall_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (ctl == C_MEM) stall_cycles++;
      @(negedge clk);
    end
    chk("timeout_stall_cycles", 32'(stall_cycles), 32'd16);
    #1;
    chk("timeout_release_ctl", 32'(ctl), 32'(C_NONE));
    chk("timeout_memerr_before", 32'(MemErr), 32'd0);
    @(negedge clk);
    MemReqM = 0;
    #1;
    chk("timeout_memerr_set", 32'(MemErr), 32'd1);
    chk("timeout_idle_ctl", 32'(ctl), 32'(C_NONE));
    @(negedge clk);
    #1;
    chk("memerr_sticky", 32'(MemErr), 32'd1);
`ifdef HAZARD_PERF_EN
    chk("timeout_memstallcnt", MemStallCnt, 32'd16);
`else
    chk("timeout_memstallcnt", MemStallCnt, 32'd0);
`endif

    // Reset asserted mid-WAIT.
    @(negedge clk);
    MemReqM = 1; MemReadyM = 0; RdM = 5; RegWriteM = 1; Rs1E = 5;
    repeat (3) @(negedge clk);
    #1;
    chk("midwait_stalling", 32'(ctl), 32'(C_MEM));
    reset = 1;
    #1;
    chk("midwait_reset_ctl", 32'(ctl), 32'(C_NONE));
    chk("midwait_reset_fwd", 32'(ForwardAE), 32'd0);
    chk("midwait_reset_memerr", 32'(MemErr), 32'd0);
    chk("midwait_reset_cnt", MemStallCnt, 32'd0);
    @(negedge clk);
    reset = 0; MemReqM = 0; MemReadyM = 0;
    #1;
    chk("post_reset_idle_ctl", 32'(ctl), 32'(C_NONE));
    chk("post_reset_fwd", 32'(ForwardAE), 32'd2);
    clear_inputs();

    // Four wait cycles then acknowledge.
    @(negedge clk);
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("wait4_cyc%0d", i), 32'(ctl), 32'(C_MEM));
      @(negedge clk);
    end
    MemReadyM = 1;
    #1;
    chk("wait4_release", 32'(ctl), 32'(C_NONE));
    @(negedge clk);
    MemReqM = 0; MemReadyM = 0;
    #1;
    chk("wait4_memerr", 32'(MemErr), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("wait4_memstallcnt", MemStallCnt, 32'd4);
`else
    chk("wait4_memstallcnt", MemStallCnt, 32'd0);
`endif

    // Branch resolved during a memory stall, then back-to-back access.
    @(negedge clk);
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("br_hold_cyc%0d", i), 32'(ctl), 32'(C_MEM));
      @(negedge clk);
    end
    MemReadyM = 1;
    #1;
    chk("br_flush_after_release", 32'(ctl), 32'(C_BR));
    @(negedge clk);
    PCSrcE = 0; MemReqM = 1; MemReadyM = 0;
    #1;
    chk("b2b_reenter", 32'(ctl), 32'(C_MEM));
    @(negedge clk);
    MemReadyM = 1;
    #1;
    chk("b2b_release", 32'(ctl), 32'(C_NONE));
    @(negedge clk);
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
